// File: rtl/data_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_pkg
// Purpose  : Shared encodings for the MEM-stage data memory responder:
//            access-size codes, read/write polarity, FSM state type and the
//            alignment/legality check used when a request is accepted.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Halfwords need an even address, words a multiple of 4; the reserved
  // size code is always illegal.
  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_fault = 1'b0;
      SIZE_HALF: is_fault = addr_lo[0];
      SIZE_WORD: is_fault = (addr_lo != 2'b00);
      default:   is_fault = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_if
// Purpose  : Request/response bundle between the EX/MEM pipeline register
//            (master) and the data memory responder (slave).
// Signals  : Enable_In, rw_In, Size_In[1:0], Address_In[31:0], Data_In[31:0]
//            (master -> slave); Mem_Data_Out[31:0], Done_Out, Fault_Out,
//            Stall_Out (slave -> master).
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_responder_if;

  logic        Enable_In;
  logic        rw_In;
  logic [1:0]  Size_In;
  logic [31:0] Address_In;
  logic [31:0] Data_In;
  logic [31:0] Mem_Data_Out;
  logic        Done_Out;
  logic        Fault_Out;
  logic        Stall_Out;

  modport master (
    output Enable_In, rw_In, Size_In, Address_In, Data_In,
    input  Mem_Data_Out, Done_Out, Fault_Out, Stall_Out
  );

  modport slave (
    input  Enable_In, rw_In, Size_In, Address_In, Data_In,
    output Mem_Data_Out, Done_Out, Fault_Out, Stall_Out
  );

endinterface
`default_nettype wire

// File: rtl/data_memory_responder_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_array
// Purpose  : DEPTH_BYTES x 8 byte RAM with a 4-lane window starting at
//            base_addr. Lane k maps to byte base_addr+k (wrapping) and to
//            data bits [31-8k -: 8], giving a big-endian view.
// Ports    : clk        - rising-edge clock
//            base_addr  - byte address of lane 0
//            lane_we    - per-lane write enables (bit k = lane k)
//            wr_data    - write data, lane 0 in bits [31:24]
//            rd_data    - asynchronous read of the 4-byte window
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_array #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        lane_we,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data
);

  logic [7:0]        mem [DEPTH_BYTES];
  logic [ADDR_W-1:0] lane_addr [4];

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      // Address arithmetic at ADDR_W bits gives the modulo-depth wrap.
      assign lane_addr[k]           = base_addr + ADDR_W'(k);
      assign rd_data[31-8*k -: 8]   = mem[lane_addr[k]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) begin
        mem[lane_addr[k]] <= wr_data[31-8*k -: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : MEM-stage data memory. Accepts one byte/halfword/word access
//            from EX/MEM, holds the pipeline with Stall_Out for WAIT_CYCLES
//            extra cycles, then pulses Done_Out for one cycle with
//            zero-extended read data. Misaligned or reserved-size requests
//            complete immediately with Fault_Out and touch nothing.
// Ports    : CLK  - rising-edge clock
//            CLR  - synchronous active-high reset
//            bus  - data_memory_responder_if.slave request/response bundle
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    CLK,
  input  logic                    CLR,
  data_memory_responder_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);

  state_t            state;
  logic [3:0]        count;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              fault_q;

  logic              access_now;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       read_ext;
  logic              unused_addr_bits;

  // Upper address bits are deliberately ignored (wrap modulo depth).
  assign unused_addr_bits = ^bus.Address_In[31:ADDR_W];

  assign access_now = (state == WAIT) && (count == 4'd0);

  // Lane steering: the addressed byte is always lane 0, so narrow stores
  // place their data at the top of the window and narrow loads pull it
  // down from the top.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = 32'h0;
    read_ext   = 32'h0;
    case (size_q)
      SIZE_BYTE: begin
        lane_we    = 4'b0001;
        lane_wdata = {data_q[7:0], 24'h0};
        read_ext   = {24'h0, ram_rdata[31:24]};
      end
      SIZE_HALF: begin
        lane_we    = 4'b0011;
        lane_wdata = {data_q[15:0], 16'h0};
        read_ext   = {16'h0, ram_rdata[31:16]};
      end
      SIZE_WORD: begin
        lane_we    = 4'b1111;
        lane_wdata = data_q;
        read_ext   = ram_rdata;
      end
      default: ;
    endcase
    // A reset on the access edge drops the pending store.
    if (!(access_now && (rw_q == RW_WRITE) && !CLR)) begin
      lane_we = 4'b0000;
    end
  end

  data_ram_array #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_ram (
    .clk       (CLK),
    .base_addr (addr_q),
    .lane_we   (lane_we),
    .wr_data   (lane_wdata),
    .rd_data   (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= IDLE;
      count   <= 4'd0;
      rw_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      data_q  <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          rdata_q <= 32'h0;
          if (bus.Enable_In) begin
            rw_q   <= bus.rw_In;
            size_q <= bus.Size_In;
            addr_q <= bus.Address_In[ADDR_W-1:0];
            data_q <= bus.Data_In;
            if (is_fault(bus.Size_In, bus.Address_In[1:0])) begin
              fault_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              count <= 4'(WAIT_CYCLES);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            rdata_q <= (rw_q == RW_WRITE) ? 32'h0 : read_ext;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // The request still on the bus is the one just completed.
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          rdata_q <= 32'h0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Mem_Data_Out = rdata_q;
  assign bus.Done_Out     = done_q;
  assign bus.Fault_Out    = fault_q;
  assign bus.Stall_Out    = ((state == IDLE) && bus.Enable_In) || (state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Self-checking bench for data_memory_responder: directed vector
//            table, randomized accesses against a byte-array memory model,
//            reset-during-write and back-to-back sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int DEPTH = 256;
  localparam int W1    = 1;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  always #5 CLK = ~CLK;

  data_memory_responder_if bus1 ();
  data_memory_responder_if bus0 ();

  data_memory_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .CLK (CLK), .CLR (CLR), .bus (bus1.slave)
  );
  data_memory_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK (CLK), .CLR (CLR), .bus (bus0.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_mem [DEPTH];

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    logic        chkd;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (addr % 2) != 0;
    if (size == 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Big-endian: first byte of the access holds the most significant byte.
  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    int n = nbytes(size);
    for (int i = 0; i < n; i++) begin
      int unsigned idx = (addr + 32'(i)) % DEPTH;
      ref_mem[idx] = 8'(data >> (8 * (n - 1 - i)));
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] r = 32'h0;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) begin
      int unsigned idx = (addr + 32'(i)) % DEPTH;
      r = (r << 8) | {24'h0, ref_mem[idx]};
    end
    return r;
  endfunction

  // Presents one request on bus1, holds it until Done_Out, then checks
  // latency, stall length, fault and data. Called mid-cycle.
  task automatic access1(input string tag, input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_fault, input logic chkd, input logic [31:0] exp_data);
    int stalls = 0;
    int done_at = -1;
    int exp_lat = exp_fault ? 1 : W1 + 2;
    bus1.Enable_In  = 1'b1;
    bus1.rw_In      = rw;
    bus1.Size_In    = size;
    bus1.Address_In = addr;
    bus1.Data_In    = data;
    for (int cyc = 0; cyc < 40 && done_at < 0; cyc++) begin
      #1;
      if (bus1.Done_Out) begin
        done_at = cyc;
        chk({tag, " stall_in_done"}, 32'(bus1.Stall_Out), 32'd0);
        chk({tag, " fault"}, 32'(bus1.Fault_Out), 32'(exp_fault));
        if (chkd) chk({tag, " rdata"}, bus1.Mem_Data_Out, exp_data);
        bus1.Enable_In = 1'b0;
      end else if (bus1.Stall_Out) begin
        stalls++;
      end
      @(posedge CLK); #1;
    end
    chk({tag, " latency"}, 32'(done_at), 32'(exp_lat));
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    #1;
    chk({tag, " done_cleared"}, 32'(bus1.Done_Out), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    logic        b2b_rw   [3];
    logic [1:0]  b2b_size [3];
    logic [31:0] b2b_exp  [3];
    int done_cyc[$];
    int idx;

    vecs[0]  = '{1'b1, SIZE_WORD, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, SIZE_WORD, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, SIZE_BYTE, 32'h011, 32'h000000AA, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, SIZE_WORD, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
    vecs[4]  = '{1'b0, SIZE_HALF, 32'h012, 32'h0,        1'b0, 1'b1, 32'h0000BEEF};
    vecs[5]  = '{1'b1, SIZE_HALF, 32'h013, 32'h00005555, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, SIZE_WORD, 32'h010, 32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
    vecs[7]  = '{1'b1, SIZE_WORD, 32'h020, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, SIZE_RSVD, 32'h020, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, SIZE_RSVD, 32'h020, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b0, SIZE_WORD, 32'h020, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    vecs[11] = '{1'b1, SIZE_WORD, 32'h110, 32'h12345678, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, SIZE_WORD, 32'h010, 32'h0,        1'b0, 1'b1, 32'h12345678};
    vecs[13] = '{1'b0, SIZE_BYTE, 32'h113, 32'h0,        1'b0, 1'b1, 32'h00000078};
    vecs[14] = '{1'b0, SIZE_WORD, 32'h012, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[15] = '{1'b1, SIZE_WORD, 32'h014, 32'h01020304, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b1, SIZE_HALF, 32'h016, 32'h9999ABCD, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, SIZE_WORD, 32'h014, 32'h0,        1'b0, 1'b1, 32'h0102ABCD};
    vecs[18] = '{1'b0, SIZE_HALF, 32'h010, 32'h0,        1'b0, 1'b1, 32'h00001234};
    vecs[19] = '{1'b0, SIZE_BYTE, 32'h017, 32'h0,        1'b0, 1'b1, 32'h000000CD};

    bus1.Enable_In = 1'b0; bus1.rw_In = 1'b0; bus1.Size_In = 2'd0;
    bus1.Address_In = 32'h0; bus1.Data_In = 32'h0;
    bus0.Enable_In = 1'b0; bus0.rw_In = 1'b0; bus0.Size_In = 2'd0;
    bus0.Address_In = 32'h0; bus0.Data_In = 32'h0;

    // Reset state
    CLR = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset done1",  32'(bus1.Done_Out), 32'd0);
    chk("reset fault1", 32'(bus1.Fault_Out), 32'd0);
    chk("reset data1",  bus1.Mem_Data_Out, 32'h0);
    chk("reset stall1", 32'(bus1.Stall_Out), 32'd0);
    chk("reset done0",  32'(bus0.Done_Out), 32'd0);
    chk("reset stall0", 32'(bus0.Stall_Out), 32'd0);
    CLR = 1'b0;
    @(posedge CLK); #1;

    // Preload every word so the model knows the whole RAM.
    for (int a = 0; a < DEPTH; a += 4) begin
      logic [31:0] d = $urandom;
      access1("preload", 1'b1, SIZE_WORD, 32'(a), d, 1'b0, 1'b0, 32'h0);
      model_write(32'(a), SIZE_WORD, d);
    end

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      access1($sformatf("vec%0d", i), vecs[i].rw, vecs[i].size, vecs[i].addr,
              vecs[i].data, vecs[i].fault, vecs[i].chkd, vecs[i].rdata);
      if (vecs[i].rw && !vecs[i].fault) model_write(vecs[i].addr, vecs[i].size, vecs[i].data);
    end

    // Randomized accesses against the model
    for (int i = 0; i < 200; i++) begin
      logic        rw   = 1'($urandom_range(0, 1));
      int unsigned sr   = $urandom_range(0, 9);
      logic [1:0]  size = (sr < 3) ? SIZE_BYTE : (sr < 6) ? SIZE_HALF : (sr < 9) ? SIZE_WORD : SIZE_RSVD;
      logic [31:0] addr = 32'($urandom_range(0, 511));
      logic [31:0] data = $urandom;
      logic        f;
      if ($urandom_range(0, 3) != 0 && size != SIZE_RSVD) addr = addr - (addr % 32'(nbytes(size)));
      f = model_fault(size, addr);
      access1($sformatf("rand%0d", i), rw, size, addr, data, f, f || !rw,
              (f || rw) ? 32'h0 : model_read(addr, size));
      if (rw && !f) model_write(addr, size, data);
    end

    // Reset on the very edge that would perform a pending store to 0x40.
    bus1.Enable_In = 1'b1; bus1.rw_In = 1'b1; bus1.Size_In = SIZE_WORD;
    bus1.Address_In = 32'h40; bus1.Data_In = 32'h11223344;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    CLR = 1'b1; bus1.Enable_In = 1'b0;
    @(posedge CLK); #1;
    #1;
    chk("clr done",  32'(bus1.Done_Out), 32'd0);
    chk("clr fault", 32'(bus1.Fault_Out), 32'd0);
    chk("clr data",  bus1.Mem_Data_Out, 32'h0);
    chk("clr stall", 32'(bus1.Stall_Out), 32'd0);
    bus1.Enable_In = 1'b1;
    #1;
    chk("clr stall_follows_enable", 32'(bus1.Stall_Out), 32'd1);
    @(posedge CLK); #1;
    chk("clr held done", 32'(bus1.Done_Out), 32'd0);
    CLR = 1'b0; bus1.Enable_In = 1'b0;
    @(posedge CLK); #1;
    access1("clr readback", 1'b0, SIZE_WORD, 32'h40, 32'h0, 1'b0, 1'b1,
            model_read(32'h40, SIZE_WORD));

    // Back-to-back with Enable_In held high, zero wait states.
    b2b_rw[0] = 1'b1; b2b_size[0] = SIZE_WORD; b2b_addr[0] = 32'h000; b2b_data[0] = 32'hA1B2C3D4; b2b_exp[0] = 32'h0;
    b2b_rw[1] = 1'b0; b2b_size[1] = SIZE_WORD; b2b_addr[1] = 32'h000; b2b_data[1] = 32'h0;        b2b_exp[1] = 32'hA1B2C3D4;
    b2b_rw[2] = 1'b0; b2b_size[2] = SIZE_BYTE; b2b_addr[2] = 32'h103; b2b_data[2] = 32'h0;        b2b_exp[2] = 32'h000000D4;
    idx = 0;
    bus0.Enable_In = 1'b1; bus0.rw_In = b2b_rw[0]; bus0.Size_In = b2b_size[0];
    bus0.Address_In = b2b_addr[0]; bus0.Data_In = b2b_data[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      #1;
      if (bus0.Done_Out) begin
        done_cyc.push_back(cyc);
        chk("b2b stall_in_done", 32'(bus0.Stall_Out), 32'd0);
        if (idx < 3 && !b2b_rw[idx]) chk($sformatf("b2b rdata%0d", idx), bus0.Mem_Data_Out, b2b_exp[idx]);
        idx++;
        if (idx < 3) begin
          bus0.rw_In = b2b_rw[idx]; bus0.Size_In = b2b_size[idx];
          bus0.Address_In = b2b_addr[idx]; bus0.Data_In = b2b_data[idx];
        end else begin
          bus0.Enable_In = 1'b0;
        end
      end
      @(posedge CLK); #1;
    end
    chk("b2b done_count", 32'(done_cyc.size()), 32'd3);
    for (int i = 0; i < done_cyc.size() && i < 3; i++) begin
      chk($sformatf("b2b done_cycle%0d", i), 32'(done_cyc[i]), 32'(2 + 3 * i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
